// File: rtl/tap_recorder_if.sv
// Recorder-side bundle: record control and tape-out bit in, tap memory write port and status out.
interface tap_recorder_if #(parameter int ADDR_W = 16);
   logic              rec;
   logic              tape_out;
   logic [ADDR_W-1:0] wr_address;
   logic [7:0]        wr_data;
   logic              wr_en;
   logic              busy;
   logic              full;
   logic [7:0]        block_count;
   logic [ADDR_W-1:0] tape_end;

   modport master (output rec, tape_out,
                   input  wr_address, wr_data, wr_en, busy, full, block_count, tape_end);
   modport slave  (input  rec, tape_out,
                   output wr_address, wr_data, wr_en, busy, full, block_count, tape_end);
endinterface

// File: rtl/tap_recorder.sv
// Tape SAVE path: times tape-out half-periods, locks on pilot+sync, decodes bytes and
// writes a .TAP image (LE length header + data) into tap memory.
module tap_recorder #(
   parameter int ADDR_W      = 16,
   parameter int PILOT_MIN_T = 1900,
   parameter int PILOT_MAX_T = 2500,
   parameter int PILOT_COUNT = 256,
   parameter int SYNC_MAX_T  = 1000,
   parameter int BIT_SPLIT_T = 2565,
   parameter int TIMEOUT_T   = 350000
) (
   input  logic         clock,
   input  logic         reset,
   tap_recorder_if.slave bus
);
   localparam int CNT_W = $clog2(TIMEOUT_T + 1);
   localparam int PC_W  = $clog2(PILOT_COUNT + 1);
   localparam logic [ADDR_W:0] TOP = {1'b0, {ADDR_W{1'b1}}};

   typedef enum logic [2:0] {
      S_IDLE, S_SEEK, S_SYNC2, S_DATA_H1, S_DATA_H2, S_LEN_LO, S_LEN_HI, S_FULL
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        sync_q, sync_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, h1_q, h1_d;
   logic [PC_W-1:0]   pilot_q, pilot_d;
   logic [2:0]        bitcnt_q, bitcnt_d;
   logic [7:0]        shreg_q, shreg_d, byte_data_q, byte_data_d, blk_cnt_q, blk_cnt_d;
   logic [15:0]       len_q, len_d;
   logic [ADDR_W:0]   base_q, base_d;
   logic [ADDR_W-1:0] byte_addr_q, byte_addr_d;
   logic              byte_we_q, byte_we_d, full_q, full_d;

   logic              rec, tog, tmo, is_pilot, is_sync, bit_val, byte_done, blk_ovf;
   logic [ADDR_W:0]   byte_addr_w;
   logic [7:0]        byte_w;

   assign rec         = bus.rec;
   assign tog         = sync_q[2] ^ sync_q[1];
   // Fires once on the way to saturation; a coincident edge takes priority.
   assign tmo         = !tog && (cnt_q == CNT_W'(TIMEOUT_T - 1));
   assign is_pilot    = (cnt_q >= CNT_W'(PILOT_MIN_T)) && (cnt_q <= CNT_W'(PILOT_MAX_T));
   assign is_sync     = cnt_q <= CNT_W'(SYNC_MAX_T);
   assign bit_val     = ({1'b0, h1_q} + {1'b0, cnt_q}) > (CNT_W+1)'(BIT_SPLIT_T);
   assign byte_w      = {shreg_q[6:0], bit_val};
   assign byte_addr_w = base_q + (ADDR_W+1)'(2) + (ADDR_W+1)'(len_q);
   assign byte_done   = rec && (state_q == S_DATA_H2) && tog && (bitcnt_q == 3'd7);
   assign blk_ovf     = (base_q + (ADDR_W+1)'(2)) > TOP;

   always_ff @(posedge clock) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!rec && state_q != S_FULL) state_d = S_IDLE;
      else begin
         case (state_q)
            S_IDLE:    state_d = S_SEEK;
            S_SEEK:    if (tog && is_sync && pilot_q >= PC_W'(PILOT_COUNT)) state_d = S_SYNC2;
            S_SYNC2: begin
               if (tog)      state_d = !is_sync ? S_SEEK : (blk_ovf ? S_FULL : S_DATA_H1);
               else if (tmo) state_d = S_SEEK;
            end
            // full_q here means the top byte just went out: close the block.
            S_DATA_H1: begin
               if (full_q)   state_d = S_LEN_LO;
               else if (tog) state_d = S_DATA_H2;
               else if (tmo) state_d = (len_q != 16'd0) ? S_LEN_LO : S_SEEK;
            end
            S_DATA_H2: begin
               if (tog)      state_d = S_DATA_H1;
               else if (tmo) state_d = (len_q != 16'd0) ? S_LEN_LO : S_SEEK;
            end
            S_LEN_LO:  state_d = S_LEN_HI;
            S_LEN_HI:  state_d = full_q ? S_FULL : S_SEEK;
            default:   state_d = S_FULL;
         endcase
      end
   end

   always_comb begin
      sync_d      = {sync_q[1:0], bus.tape_out};
      cnt_d       = tog ? CNT_W'(1) : ((cnt_q == CNT_W'(TIMEOUT_T)) ? cnt_q : cnt_q + CNT_W'(1));
      h1_d        = h1_q;
      pilot_d     = '0;
      bitcnt_d    = bitcnt_q;
      shreg_d     = shreg_q;
      len_d       = len_q;
      base_d      = base_q;
      blk_cnt_d   = blk_cnt_q;
      full_d      = full_q;
      byte_we_d   = 1'b0;
      byte_addr_d = byte_addr_q;
      byte_data_d = byte_data_q;
      if (state_q == S_SEEK)
         pilot_d = !tog ? pilot_q :
                   (!is_pilot ? '0 : ((pilot_q == PC_W'(PILOT_COUNT)) ? pilot_q : pilot_q + PC_W'(1)));
      if (rec && state_q == S_SYNC2 && tog && is_sync) begin
         len_d    = '0;
         bitcnt_d = '0;
         if (blk_ovf) full_d = 1'b1;
      end
      if (state_q == S_DATA_H1 && tog) h1_d = cnt_q;
      if (state_q == S_DATA_H2 && tog) begin
         shreg_d  = byte_w;
         bitcnt_d = bitcnt_q + 3'd1;
      end
      if (byte_done) begin
         byte_we_d   = 1'b1;
         byte_addr_d = byte_addr_w[ADDR_W-1:0];
         byte_data_d = byte_w;
         len_d       = len_q + 16'd1;
         if (byte_addr_w == TOP) full_d = 1'b1;
      end
      if (rec && state_q == S_LEN_HI) begin
         base_d    = base_q + (ADDR_W+1)'(len_q) + (ADDR_W+1)'(2);
         blk_cnt_d = blk_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q <= '0; cnt_q <= '0; h1_q <= '0; pilot_q <= '0; bitcnt_q <= '0;
         shreg_q <= '0; len_q <= '0; base_q <= '0; blk_cnt_q <= '0; full_q <= 1'b0;
         byte_we_q <= 1'b0; byte_addr_q <= '0; byte_data_q <= '0;
      end else begin
         sync_q <= sync_d; cnt_q <= cnt_d; h1_q <= h1_d; pilot_q <= pilot_d; bitcnt_q <= bitcnt_d;
         shreg_q <= shreg_d; len_q <= len_d; base_q <= base_d; blk_cnt_q <= blk_cnt_d; full_q <= full_d;
         byte_we_q <= byte_we_d; byte_addr_q <= byte_addr_d; byte_data_q <= byte_data_d;
      end
   end

   always_comb begin
      bus.wr_en      = byte_we_q;
      bus.wr_address = byte_addr_q;
      bus.wr_data    = byte_data_q;
      if (state_q == S_LEN_LO) begin
         bus.wr_en      = 1'b1;
         bus.wr_address = base_q[ADDR_W-1:0];
         bus.wr_data    = len_q[7:0];
      end else if (state_q == S_LEN_HI) begin
         bus.wr_en      = 1'b1;
         bus.wr_address = ADDR_W'(base_q + (ADDR_W+1)'(1));
         bus.wr_data    = len_q[15:8];
      end
      bus.busy        = (state_q == S_SYNC2) || (state_q == S_DATA_H1) || (state_q == S_DATA_H2) ||
                        (state_q == S_LEN_LO) || (state_q == S_LEN_HI);
      bus.full        = full_q;
      bus.block_count = blk_cnt_q;
      bus.tape_end    = base_q[ADDR_W-1:0];
   end
endmodule
